// File: rtl/regfile_wb_queue.sv
// Writeback buffer in front of the register-file write port: DEPTH-entry FIFO, one registered write per cycle.
// Optional forwarding lookup ports are enabled by defining REGFILE_WB_FWD_EN.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 32,
    parameter int RW    = 5
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [RW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    input  logic          drain_hold,
`ifdef REGFILE_WB_FWD_EN
    input  logic [RW-1:0] fwd_regA,
    input  logic [RW-1:0] fwd_regB,
    output logic          fwd_hitA,
    output logic          fwd_hitB,
    output logic [DW-1:0] fwd_dataA,
    output logic [DW-1:0] fwd_dataB,
`endif
    output logic          rf_writeEnable,
    output logic [RW-1:0] rf_writeReg,
    output logic [DW-1:0] rf_writeData,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem_data_q [DEPTH];
    logic [DW-1:0] mem_data_d [DEPTH];
    logic [RW-1:0] mem_reg_q  [DEPTH];
    logic [RW-1:0] mem_reg_d  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          we_q, we_d;
    logic [RW-1:0] wreg_q, wreg_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic push;
    logic pop;

    assign wb_ready       = (count_q != (AW+1)'(DEPTH));
    assign count          = count_q;
    assign rf_writeEnable = we_q;
    assign rf_writeReg    = wreg_q;
    assign rf_writeData   = wdata_q;

    // Writes to r0 complete the handshake but are discarded.
    assign push = wb_valid && wb_ready && (wb_reg != '0);
    assign pop  = (count_q != '0) && !drain_hold;

    always_comb begin
        mem_data_d = mem_data_q;
        mem_reg_d  = mem_reg_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        we_d       = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;

        if (push) begin
            mem_data_d[wr_ptr_q] = wb_data;
            mem_reg_d[wr_ptr_q]  = wb_reg;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            we_d     = 1'b1;
            wreg_d   = mem_reg_q[rd_ptr_q];
            wdata_d  = mem_data_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    // Storage needs no reset: only entries inside the valid window are ever read.
    always_ff @(posedge clock) begin
        mem_data_q <= mem_data_d;
        mem_reg_q  <= mem_reg_d;
    end

`ifdef REGFILE_WB_FWD_EN
    // Scan output stage first, then FIFO oldest to newest, so the youngest match wins.
    function automatic logic [DW:0] fwd_lookup(input logic [RW-1:0] r);
        logic [DW:0] res;
        res = '0;
        if (we_q && (wreg_q == r)) res = {1'b1, wdata_q};
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((AW+1)'(i) < count_q) && (mem_reg_q[rd_ptr_q + AW'(i)] == r))
                res = {1'b1, mem_data_q[rd_ptr_q + AW'(i)]};
        end
        if (r == '0) res = '0;
        return res;
    endfunction

    logic [DW:0] fwd_a, fwd_b;

    always_comb begin
        fwd_a = fwd_lookup(fwd_regA);
        fwd_b = fwd_lookup(fwd_regB);
    end

    assign fwd_hitA  = fwd_a[DW];
    assign fwd_dataA = fwd_a[DW-1:0];
    assign fwd_hitB  = fwd_b[DW];
    assign fwd_dataB = fwd_b[DW-1:0];
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue; forwarding checks run when REGFILE_WB_FWD_EN is defined.
module tb_regfile_wb_queue;

    logic        clock;
    logic        ctrl_reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        drain_hold;
    logic        rf_writeEnable;
    logic [4:0]  rf_writeReg;
    logic [31:0] rf_writeData;
    logic [2:0]  count;
`ifdef REGFILE_WB_FWD_EN
    logic [4:0]  fwd_regA, fwd_regB;
    logic        fwd_hitA, fwd_hitB;
    logic [31:0] fwd_dataA, fwd_dataB;
`endif

    int total = 0;
    int bad   = 0;

    regfile_wb_queue #(.DEPTH(4), .AW(2), .DW(32), .RW(5)) dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .drain_hold     (drain_hold),
`ifdef REGFILE_WB_FWD_EN
        .fwd_regA       (fwd_regA),
        .fwd_regB       (fwd_regB),
        .fwd_hitA       (fwd_hitA),
        .fwd_hitB       (fwd_hitB),
        .fwd_dataA      (fwd_dataA),
        .fwd_dataB      (fwd_dataB),
`endif
        .rf_writeEnable (rf_writeEnable),
        .rf_writeReg    (rf_writeReg),
        .rf_writeData   (rf_writeData),
        .count          (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [4:0] r, input logic [31:0] d);
        check({tag, "_we"},   64'(rf_writeEnable), 64'd1);
        check({tag, "_reg"},  64'(rf_writeReg),    64'(r));
        check({tag, "_data"}, 64'(rf_writeData),   64'(d));
    endtask

    initial begin
        ctrl_reset = 1'b0;
        wb_valid   = 1'b0;
        wb_reg     = '0;
        wb_data    = '0;
        drain_hold = 1'b0;
`ifdef REGFILE_WB_FWD_EN
        fwd_regA   = '0;
        fwd_regB   = '0;
`endif
        #12;
        check("rst_we",    64'(rf_writeEnable), 64'd0);
        check("rst_count", 64'(count),          64'd0);
        check("rst_reg",   64'(rf_writeReg),    64'd0);
        check("rst_data",  64'(rf_writeData),   64'd0);
        ctrl_reset = 1'b1;
        tick();
        check("rel_ready", 64'(wb_ready), 64'd1);

        // Single push, two-edge latency to the write port
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        wb_valid = 1'b0;
        check("t2_count1", 64'(count),          64'd1);
        check("t2_we0",    64'(rf_writeEnable), 64'd0);
        tick();
        check_write("t2_write", 5'd5, 32'hDEADBEEF);
        check("t2_count0", 64'(count), 64'd0);
        tick();
        check("t2_we_off",   64'(rf_writeEnable), 64'd0);
        check("t2_reg_hold", 64'(rf_writeReg),    64'd5);

        // r0 write is accepted and dropped
        wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h12345678;
        check("t3_ready", 64'(wb_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        check("t3_count", 64'(count),          64'd0);
        check("t3_we_a",  64'(rf_writeEnable), 64'd0);
        tick();
        check("t3_we_b",  64'(rf_writeEnable), 64'd0);

        // Fill under hold, back-pressure, then drain in order
        drain_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1; wb_reg = 5'(i); wb_data = 32'hA0 + 32'(i);
            tick();
        end
        check("t4_full_count", 64'(count),    64'd4);
        check("t4_full_ready", 64'(wb_ready), 64'd0);
        wb_reg = 5'd9; wb_data = 32'hA5;
        tick();
        check("t4_held_count", 64'(count),          64'd4);
        check("t4_held_we",    64'(rf_writeEnable), 64'd0);
        drain_hold = 1'b0;
        tick();
        check_write("t4_w1", 5'd1, 32'hA1);
        check("t4_c3a", 64'(count),    64'd3);
        check("t4_rdy", 64'(wb_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        check_write("t4_w2", 5'd2, 32'hA2);
        check("t4_c3b", 64'(count), 64'd3);
        tick();
        check_write("t4_w3", 5'd3, 32'hA3);
        tick();
        check_write("t4_w4", 5'd4, 32'hA4);
        tick();
        check_write("t4_w5", 5'd9, 32'hA5);
        check("t4_c0", 64'(count), 64'd0);
        tick();
        check("t4_idle", 64'(rf_writeEnable), 64'd0);

        // Steady push+pop at count=2 with pointer wrap
        drain_hold = 1'b1;
        wb_valid = 1'b1; wb_reg = 5'd20; wb_data = 32'hB0;
        tick();
        wb_reg = 5'd21; wb_data = 32'hB1;
        tick();
        check("t5_pre_count", 64'(count), 64'd2);
        drain_hold = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wb_reg = 5'(22 + k); wb_data = 32'hB2 + 32'(k);
            tick();
            check_write($sformatf("t5_pp%0d", k), 5'(20 + k), 32'hB0 + 32'(k));
            check($sformatf("t5_cnt%0d", k), 64'(count), 64'd2);
        end
        wb_valid = 1'b0;
        tick();
        check_write("t5_tail0", 5'd28, 32'hB8);
        tick();
        check_write("t5_tail1", 5'd29, 32'hB9);
        check("t5_end_count", 64'(count), 64'd0);
        tick();

        // Asynchronous reset mid-burst
        drain_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; wb_reg = 5'(10 + i); wb_data = 32'hC0 + 32'(i);
            tick();
        end
        wb_valid = 1'b0;
        drain_hold = 1'b0;
        tick();
        check_write("t1_pre", 5'd10, 32'hC0);
        check("t1_pre_count", 64'(count), 64'd2);
        #2 ctrl_reset = 1'b0;
        #1;
        check("t1_rst_we",    64'(rf_writeEnable), 64'd0);
        check("t1_rst_count", 64'(count),          64'd0);
        check("t1_rst_reg",   64'(rf_writeReg),    64'd0);
        @(negedge clock);
        ctrl_reset = 1'b1;
        #1;
        check("t1_rel_ready", 64'(wb_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t1_stale%0d", i), 64'(rf_writeEnable), 64'd0);
        end

`ifdef REGFILE_WB_FWD_EN
        // Youngest match wins across FIFO and output stage
        drain_hold = 1'b1;
        wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'h11;
        tick();
        wb_data = 32'h22;
        tick();
        wb_valid = 1'b0;
        fwd_regA = 5'd7; fwd_regB = 5'd0;
        #1;
        check("t6_hitA",  64'(fwd_hitA),  64'd1);
        check("t6_dataA", 64'(fwd_dataA), 64'h22);
        check("t6_hitB",  64'(fwd_hitB),  64'd0);
        check("t6_dataB", 64'(fwd_dataB), 64'd0);
        drain_hold = 1'b0;
        tick();
        check("t6_mix_dataA", 64'(fwd_dataA), 64'h22);
        tick();
        check("t6_out_hitA",  64'(fwd_hitA),  64'd1);
        check("t6_out_dataA", 64'(fwd_dataA), 64'h22);
        tick();
        check("t6_miss_hitA",  64'(fwd_hitA),  64'd0);
        check("t6_miss_dataA", 64'(fwd_dataA), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
